custom_axi_ip_engine: RTL
=========================

Name: custom_axi_ip_engine

Overview:
Multi-channel, multi-mode compute engine that sits behind the custom AXI IP register block.
- Each of NUM_CH register channels posts a start request with an operand word.
- A round-robin arbiter serialises requests into one iterative datapath, which applies a selectable operation N times.
- The result goes back to the register block with a write-enable pulse, channel tag and status.

Parameters:
DATA_WIDTH, 32, width of data, operand and result words
NUM_CH, 4, number of request channels (power of two, >=2)
ITER_W, 8, width of the iteration-count field

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
start_i  in  NUM_CH  per-channel request pulse (1 cycle)
ch_data_i  in  NUM_CH*DATA_WIDTH  per-channel input word; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
mode_i  in  2  operation, sampled at grant (mode_e)
operand_i  in  DATA_WIDTH  second operand, sampled at grant
iter_i  in  ITER_W  iteration count, sampled at grant
result_o  out  DATA_WIDTH  result word, valid while wen_o=1
result_ch_o  out  $clog2(NUM_CH)  channel that owns result_o / err_o
wen_o  out  1  one-cycle write strobe to register block
status_o  out  2  status_e of current FSM state
pending_o  out  NUM_CH  outstanding requests
carry_o  out  1  sticky carry of current job, valid with wen_o
err_o  out  1  one-cycle pulse, invalid mode
overrun_o  out  1  one-cycle pulse, start on busy channel dropped

Behaviour:
- Reset: rst_ni is an asynchronous, active-low reset; clk_i is the clock.
- Reset values: all outputs 0, status_o=IDLE, pending=0, RR pointer=0 (channel 0 highest priority), accumulator=0.
- Pending:
  - start_i[c] sets pending[c] at the next edge.
  - If pending[c] is already 1, or c is the channel currently in BUSY/DONE, the request is dropped and overrun_o pulses the following cycle.
  - If start_i[c] arrives in the same cycle that pending[c] is cleared by a grant, set wins and pending[c] remains 1.
- Arbiter: round-robin. Search starts at (last_grant+1) mod NUM_CH. The pointer updates only on grant.
- FSM states: IDLE, BUSY, DONE, ERROR (status_e). status_o equals the state.
- IDLE:
  - If pending != 0, grant channel g, clear pending[g], and latch acc=ch_data_i[g], mode, operand, count=max(iter_i,1), tag=g, carry=0.
  - Next state is ERROR if mode==RSVD, otherwise BUSY.
  - If pending == 0, stay in IDLE.
- BUSY: each cycle update acc and decrement count. Go to DONE when count==1, otherwise stay in BUSY. Operations:
  - INC: acc+1
  - ADD: acc+operand
  - XOR: acc^operand
  - All arithmetic is modulo 2^DATA_WIDTH. Carry-out of INC/ADD ORs into carry. XOR never sets carry.
- DONE: wen_o=1, result_o=acc, result_ch_o=tag, carry_o=carry. Lasts exactly 1 cycle, then IDLE.
- ERROR: err_o=1, result_ch_o=tag, wen_o=0. Lasts 1 cycle, then IDLE. Accumulator is not written back.
- Latency: with the start edge at k, wen_o is high in the cycle after edge k+1+N (N = effective iteration count). This assumes the engine is idle and there is no contention.
- Back-to-back jobs: no IDLE bubble is skipped; minimum job spacing is N+2 cycles.
- result_o and result_ch_o hold their last values outside DONE. They are not cleared.
- Reset mid-job: the job is abandoned, all pending requests are lost, no wen_o is issued, and outputs go to reset values immediately.

Decomposition:
- Package custom_axi_ip_pkg:
  - Reuse status_e (IDLE, BUSY, DONE, ERROR).
  - Add mode_e: INC=0, ADD=1, XOR=2, RSVD=3.
- Sub-module custom_axi_ip_rr_arb, parameter NUM_CH:
  - Inputs: req, advance.
  - Outputs: grant_valid, grant_idx.
  - Owns the rotating pointer.

Test Plan:
- Single job: start_i=0001, ch_data_i[0]=0x10, mode=INC, iter=3 -> status_o IDLE,BUSY×3,DONE; wen_o at cycle 5; result_o=0x13, result_ch_o=0, carry_o=0.
- Overflow: ch1 data=0xFFFFFFFF, mode=ADD, operand=2, iter=1 -> result_o=0x00000001, carry_o=1; iter=0 behaves as iter=1.
- Round-robin: start_i=1111 in one cycle, mode=XOR, operand=0xFF, iter=1 -> results in channel order 0,1,2,3, each 3 cycles apart; a second burst is granted starting at channel 0 after pointer wrap.
- Overrun / set-wins: repeat start on pending ch2 -> overrun_o pulse, single result. Start ch0 in its grant cycle -> pending_o[0] stays 1 and a second result follows.
- Invalid mode: mode=3 on ch3 -> one ERROR cycle, err_o=1, result_ch_o=3, no wen_o; next pending job completes normally.
- Reset mid-BUSY: iter=200, deassert rst_ni after 50 cycles -> outputs 0, status_o=IDLE, pending_o=0, no wen_o thereafter.

Source files
------------

// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the custom AXI IP compute engine.
// Status and operation encodings seen by the register block.
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    INC  = 2'd0,
    ADD  = 2'd1,
    XOR  = 2'd2,
    RSVD = 2'd3
  } mode_e;

endpackage

// File: rtl/custom_axi_ip_rr_arb.sv
// Round-robin request arbiter for the compute engine.
// The pointer holds the first channel to search and moves past each grant.
module custom_axi_ip_rr_arb
  import custom_axi_ip_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int IW = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic              grant_valid,
  output logic [IW-1:0]     grant_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  // search from ptr upward; lowest offset is visited last and wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = ptr + IW'(i);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // rotate the search start only when a grant is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/custom_axi_ip_engine.sv
// Multi-channel iterative compute engine behind the AXI IP regs.
// Requests are serialised by a round-robin arbiter into one datapath.
module custom_axi_ip_engine
  import custom_axi_ip_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int ITER_W     = 8,
  localparam int IW = $clog2(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH-1:0]            start_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  input  logic [1:0]                   mode_i,
  input  logic [DATA_WIDTH-1:0]        operand_i,
  input  logic [ITER_W-1:0]            iter_i,
  output logic [DATA_WIDTH-1:0]        result_o,
  output logic [IW-1:0]                result_ch_o,
  output logic                         wen_o,
  output logic [1:0]                   status_o,
  output logic [NUM_CH-1:0]            pending_o,
  output logic                         carry_o,
  output logic                         err_o,
  output logic                         overrun_o
);

  status_e               state, state_n;
  mode_e                 mode;
  logic [NUM_CH-1:0]     pend, clr, drop;
  logic                  gv, grant, active;
  logic [IW-1:0]         gi, tag;
  logic [DATA_WIDTH-1:0] acc, opnd, acc_n;
  logic [DATA_WIDTH:0]   sum;
  logic                  carry, carry_n;
  logic [ITER_W-1:0]     cnt;
  logic                  last;
  logic [DATA_WIDTH-1:0] ch_w [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_w[c] = ch_data_i[c*DATA_WIDTH +: DATA_WIDTH];
  end

  assign grant     = (state == IDLE) && gv;
  assign active    = (state == BUSY) || (state == DONE);
  assign last      = (cnt == ITER_W'(1));
  assign status_o  = state;
  assign pending_o = pend;
  assign wen_o     = (state == DONE);
  assign err_o     = (state == ERROR);
  assign carry_o   = (state == DONE) && carry;

  custom_axi_ip_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req         (pend),
    .advance     (grant),
    .grant_valid (gv),
    .grant_idx   (gi)
  );

  // grant clears its pending bit; a start on a live request is dropped
  always_comb begin
    clr  = '0;
    drop = '0;
    if (grant) clr[gi] = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      drop[c] = start_i[c] &&
                ((pend[c] && !clr[c]) || (active && tag == IW'(c)));
    end
  end

  // pending set wins over a same-cycle grant clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend      <= '0;
      overrun_o <= 1'b0;
    end else begin
      pend      <= (pend & ~clr) | (start_i & ~drop);
      overrun_o <= |drop;
    end
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  // next-state: one job is IDLE, N x BUSY, then DONE (or ERROR)
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (gv) state_n = (mode_e'(mode_i) == RSVD) ? ERROR : BUSY;
      BUSY:  if (last) state_n = DONE;
      DONE:  state_n = IDLE;
      ERROR: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // one iteration of the selected operation with carry-out
  always_comb begin
    sum = {1'b0, acc};
    unique case (mode)
      INC:     sum = {1'b0, acc} + {{DATA_WIDTH{1'b0}}, 1'b1};
      ADD:     sum = {1'b0, acc} + {1'b0, opnd};
      XOR:     sum = {1'b0, acc ^ opnd};
      default: sum = {1'b0, acc};
    endcase
    acc_n   = sum[DATA_WIDTH-1:0];
    carry_n = carry | sum[DATA_WIDTH];
  end

  // job latch on grant, iterate in BUSY, capture result on last step
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc         <= '0;
      opnd        <= '0;
      mode        <= INC;
      cnt         <= '0;
      tag         <= '0;
      carry       <= 1'b0;
      result_o    <= '0;
      result_ch_o <= '0;
    end else if (grant) begin
      acc   <= ch_w[gi];
      opnd  <= operand_i;
      mode  <= mode_e'(mode_i);
      cnt   <= (iter_i == '0) ? ITER_W'(1) : iter_i;
      tag   <= gi;
      carry <= 1'b0;
      if (mode_e'(mode_i) == RSVD) result_ch_o <= gi;
    end else if (state == BUSY) begin
      acc   <= acc_n;
      carry <= carry_n;
      cnt   <= cnt - ITER_W'(1);
      if (last) begin
        result_o    <= acc_n;
        result_ch_o <= tag;
      end
    end
  end

endmodule
